// File: rtl/pe_row_mac.sv
// pe_row_mac: one PE column slot. Local ifmap/filter/psum scratchpads plus a
// sequenced multi-tap MAC: psum[p] += sum_k ifmap[ib+k]*filter[fb+k].
// Optional build macro PE_SATURATE_EN: the written-back result saturates to
// 2^DATA_W-1 instead of truncating.
module pe_row_mac #(
  parameter int DATA_W    = 16,
  parameter int IFMAP_AW  = 4,
  parameter int FILTER_AW = 8,
  parameter int PSUM_AW   = 5,
  parameter int LEN_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_ifmap,
  input  logic [IFMAP_AW-1:0]  addr_ifmap,
  input  logic [DATA_W-1:0]    input_ifmap,
  input  logic                 wr_en_filter,
  input  logic [FILTER_AW-1:0] addr_filter,
  input  logic [DATA_W-1:0]    input_filter,
  input  logic                 wr_en_psum,
  input  logic [PSUM_AW-1:0]   addr_psum,
  input  logic [DATA_W-1:0]    input_psum,
  input  logic                 start,
  input  logic [LEN_W-1:0]     tap_len,
  input  logic [IFMAP_AW-1:0]  ifmap_base,
  input  logic [FILTER_AW-1:0] filter_base,
  input  logic [PSUM_AW-1:0]   psum_sel,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_W-1:0]    output_psum
);

  localparam int AW    = 2 * DATA_W;
  localparam int IF_D  = 1 << IFMAP_AW;
  localparam int FL_D  = 1 << FILTER_AW;
  localparam int PS_D  = 1 << PSUM_AW;

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} state_t;

  state_t state_q, state_d;

  logic [IF_D-1:0][DATA_W-1:0] ifmap_q,  ifmap_d;
  logic [FL_D-1:0][DATA_W-1:0] filter_q, filter_d;
  logic [PS_D-1:0][DATA_W-1:0] psum_q,   psum_d;

  logic [AW-1:0]        acc_q, acc_d;
  logic [LEN_W-1:0]     k_q, k_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [IFMAP_AW-1:0]  ib_q, ib_d;
  logic [FILTER_AW-1:0] fb_q, fb_d;
  logic [PSUM_AW-1:0]   ps_q, ps_d;
  logic [DATA_W-1:0]    out_q, out_d;

  logic [IFMAP_AW-1:0]  if_addr;
  logic [FILTER_AW-1:0] fl_addr;
  logic [AW-1:0]        prod;
  logic [LEN_W-1:0]     k_next;
  logic                 ovf;
  logic [DATA_W-1:0]    result;

  // Datapath: wrapped tap addresses, wide unsigned product, write-back value.
  always_comb begin
    if_addr = ib_q + IFMAP_AW'(k_q);
    fl_addr = fb_q + FILTER_AW'(k_q);
    prod    = AW'(ifmap_q[if_addr]) * AW'(filter_q[fl_addr]);
    k_next  = k_q + 1'b1;
    ovf     = |acc_q[AW-1:DATA_W];
    result  = (SAT && ovf) ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
  end

  // Scratchpad writes: host ifmap/filter writes dropped while busy, host psum
  // writes dropped only on the entry being accumulated; WB owns that entry.
  always_comb begin
    ifmap_d  = ifmap_q;
    filter_d = filter_q;
    psum_d   = psum_q;
    if (wr_en_ifmap && state_q == S_IDLE)
      ifmap_d[addr_ifmap] = input_ifmap;
    if (wr_en_filter && state_q == S_IDLE)
      filter_d[addr_filter] = input_filter;
    if (wr_en_psum && (state_q == S_IDLE || addr_psum != ps_q))
      psum_d[addr_psum] = input_psum;
    if (state_q == S_WB)
      psum_d[ps_q] = result;
  end

  // Sequencer: latch operands on start, one MAC per cycle, then write back.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    len_d   = len_q;
    ib_d    = ib_q;
    fb_d    = fb_q;
    ps_d    = ps_q;
    out_d   = out_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = tap_len;
          ib_d    = ifmap_base;
          fb_d    = filter_base;
          ps_d    = psum_sel;
          acc_d   = AW'(psum_q[psum_sel]);
          k_d     = '0;
          state_d = (tap_len != '0) ? S_MAC : S_WB;
        end
      end
      S_MAC: begin
        busy  = 1'b1;
        acc_d = acc_q + prod;
        k_d   = k_next;
        if (k_next == len_q) state_d = S_WB;
      end
      S_WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        out_d   = result;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign output_psum = out_q;

  // State registers; reset clears scratchpads and aborts any run in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ifmap_q  <= '0;
      filter_q <= '0;
      psum_q   <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      len_q    <= '0;
      ib_q     <= '0;
      fb_q     <= '0;
      ps_q     <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      ifmap_q  <= ifmap_d;
      filter_q <= filter_d;
      psum_q   <= psum_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      len_q    <= len_d;
      ib_q     <= ib_d;
      fb_q     <= fb_d;
      ps_q     <= ps_d;
      out_q    <= out_d;
    end
  end

endmodule
